// File: rtl/lm75a_pkg.sv
// Shared definitions for the LM75A target model.
//   - FSM state encoding
//   - address base, pointer codes, temperature width
//   - lm75a_tx_byte(): picks the byte served for a pointer and byte index
package lm75a_pkg;

  localparam int         TEMP_W          = 9;        // 0.5 degC two's complement
  localparam logic [3:0] LM75A_ADDR_BASE = 4'b1001;

  localparam logic [1:0] PTR_TEMP  = 2'd0;
  localparam logic [1:0] PTR_CONF  = 2'd1;
  localparam logic [1:0] PTR_THYST = 2'd2;
  localparam logic [1:0] PTR_TOS   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX_BYTE,
    ST_MASTER_ACK,
    ST_WAIT_STOP,
    ST_RX_PTR,
    ST_PTR_ACK
  } state_e;

  // Two-byte registers alternate MSB/LSB on consecutive reads; config is one
  // byte that simply repeats.
  function automatic logic [7:0] lm75a_tx_byte(input logic [1:0]        ptr,
                                               input logic              idx,
                                               input logic [TEMP_W-1:0] snap,
                                               input logic [15:0]       thyst,
                                               input logic [15:0]       tos);
    logic [7:0] b;
    case (ptr)
      PTR_CONF:  b = 8'h00;
      PTR_THYST: b = idx ? thyst[7:0] : thyst[15:8];
      PTR_TOS:   b = idx ? tos[7:0]   : tos[15:8];
      default:   b = idx ? {snap[0], 7'b0} : snap[8:1];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lm75a_target_model_i2c_bus_monitor.sv
// Oversampling front end for the I2C target.
//   clk, rst     system clock, async active-high reset
//   scl_i, sda_i raw bus lines
//   sda_o        synchronised sda level
//   scl_rise_o   one-cycle strobe on synchronised scl rise
//   scl_fall_o   one-cycle strobe on synchronised scl fall
//   start_o      sda fell while scl high
//   stop_o       sda rose while scl high
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [1:0] two-flop synchroniser, [2] history flop for edge detection.
  logic [2:0] scl_q, sda_q;

  // Reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o =  scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] &  scl_q[2];
  assign start_o    =  scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_o     =  scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/lm75a_target_model.sv
// I2C target emulating the bus side of an LM75A temperature sensor.
//   clk        system clock (>= 20x SCL)
//   rst        async active-high reset
//   temp       9-bit temperature, 0.5 degC LSB
//   scl        bus clock (input only, never driven)
//   sda        bus data, open drain (0 or z)
//   busy       addressed transaction in progress
//   addr_match pulse when our address is ACKed
//   rd_done    pulse when the master NACKs a read byte
// Optional: LM75A_POINTER_WRITE_EN enables pointer writes and the
// Tos/Thyst/config registers; without it writes are NACKed and reads
// always return temperature.
module lm75a_target_model
  import lm75a_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDR = {LM75A_ADDR_BASE, 3'b000},
  parameter logic [15:0] TOS_VALUE   = 16'h5000,
  parameter logic [15:0] THYST_VALUE = 16'h4B00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temp,
  input  logic              scl,
  inout  wire               sda,
  output logic              busy,
  output logic              addr_match,
  output logic              rd_done
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_monitor u_mon (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_sr_q, rx_sr_d;     // bits received so far this byte
  logic [6:0]        tx_sr_q, tx_sr_d;     // bits still to present
  logic              oe_q, oe_d;           // 1 = pull sda low
  logic              busy_q, busy_d;
  logic              am_q, am_d;
  logic              rdd_q, rdd_d;
  logic [TEMP_W-1:0] snap_q, snap_d;
  logic              idx_q, idx_d;         // which half of a 2-byte register
  logic              acked_q, acked_d;     // master ACKed, load next on fall
  logic [1:0]        ptr_cur;
`ifdef LM75A_POINTER_WRITE_EN
  logic [1:0]        ptr_q, ptr_d;
  logic              rw_q, rw_d;           // 1 = read transaction
  assign ptr_cur = ptr_q;
`else
  assign ptr_cur = PTR_TEMP;
`endif

  logic [7:0] rx_next;
  logic       adr_hit;
  logic       next_idx;
  logic [7:0] tx_sel;

  assign rx_next  = {rx_sr_q, sda_s};
  assign adr_hit  = (rx_next[7:1] == DEVICE_ADDR);
  assign next_idx = (state_q == ST_MASTER_ACK) ? ~idx_q : 1'b0;
  assign tx_sel   = lm75a_tx_byte(ptr_cur, next_idx, snap_q, THYST_VALUE, TOS_VALUE);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    am_d      = 1'b0;
    rdd_d     = 1'b0;
    snap_d    = snap_q;
    idx_d     = idx_q;
    acked_d   = acked_q;
`ifdef LM75A_POINTER_WRITE_EN
    ptr_d     = ptr_q;
    rw_d      = rw_q;
`endif
    // Bus conditions override everything, aborting any byte in flight.
    if (stop) begin
      state_d   = ST_IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      rx_sr_d   = '0;
    end else if (start) begin
      state_d   = ST_ADDR;
      oe_d      = 1'b0;
      bit_cnt_d = '0;
      rx_sr_d   = '0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          rx_sr_d   = rx_next[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
            if (adr_hit && rx_next[0]) state_d = ST_ADDR_ACK;
`ifdef LM75A_POINTER_WRITE_EN
            if (adr_hit) begin
              state_d = ST_ADDR_ACK;
              rw_d    = rx_next[0];
            end
`endif
          end
        end
        // First fall: assert ACK. Second fall (end of ACK clock): release
        // and present the first data bit in the same cycle.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d   = 1'b1;
            am_d   = 1'b1;
            busy_d = 1'b1;
            snap_d = temp;
          end else begin
`ifdef LM75A_POINTER_WRITE_EN
            if (!rw_q) begin
              oe_d    = 1'b0;
              state_d = ST_RX_PTR;
            end else
`endif
            begin
              idx_d     = 1'b0;
              tx_sr_d   = tx_sel[6:0];
              oe_d      = ~tx_sel[7];
              bit_cnt_d = '0;
              state_d   = ST_TX_BYTE;
            end
          end
        end
        ST_TX_BYTE: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              acked_d   = 1'b0;
              state_d   = ST_MASTER_ACK;
            end else begin
              oe_d    = ~tx_sr_q[6];
              tx_sr_d = {tx_sr_q[5:0], 1'b0};
            end
          end
        end
        ST_MASTER_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              rdd_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end else acked_d = 1'b1;
          end else if (scl_fall && acked_q) begin
            idx_d   = next_idx;
            tx_sr_d = tx_sel[6:0];
            oe_d    = ~tx_sel[7];
            state_d = ST_TX_BYTE;
          end
        end
`ifdef LM75A_POINTER_WRITE_EN
        ST_RX_PTR: if (scl_rise) begin
          rx_sr_d   = rx_next[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            ptr_d     = rx_next[1:0];
            state_d   = ST_PTR_ACK;
          end
        end
        // Any further write bytes land in WAIT_STOP with sda released,
        // which is a NACK on the bus.
        ST_PTR_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else begin
            oe_d    = 1'b0;
            state_d = ST_WAIT_STOP;
          end
        end
`endif
        ST_IDLE, ST_WAIT_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      am_q      <= 1'b0;
      rdd_q     <= 1'b0;
      snap_q    <= '0;
      idx_q     <= 1'b0;
      acked_q   <= 1'b0;
`ifdef LM75A_POINTER_WRITE_EN
      ptr_q     <= PTR_TEMP;
      rw_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      am_q      <= am_d;
      rdd_q     <= rdd_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      acked_q   <= acked_d;
`ifdef LM75A_POINTER_WRITE_EN
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
`endif
    end
  end

  assign sda        = oe_q ? 1'b0 : 1'bz;
  assign busy       = busy_q;
  assign addr_match = am_q;
  assign rd_done    = rdd_q;

endmodule

// File: tb/tb_lm75a_target_model.sv
module tb_lm75a_target_model;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] temp = 9'h033;
  logic       scl_m = 1'b1;
  logic       m_sda = 1'b1;   // 1 = master releases sda
  wire        sda;
  logic       busy, addr_match, rd_done;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  lm75a_target_model dut (
    .clk        (clk),
    .rst        (rst),
    .temp       (temp),
    .scl        (scl_m),
    .sda        (sda),
    .busy       (busy),
    .addr_match (addr_match),
    .rd_done    (rd_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int am_cnt = 0;
  int rd_cnt = 0;
  logic drv_seen = 1'b0;

  always @(negedge clk) begin
    if (addr_match) am_cnt++;
    if (rd_done)    rd_cnt++;
  end

  // Master released but line is low: someone else is pulling it.
  always @(posedge clk) if (m_sda && sda === 1'b0) drv_seen = 1'b1;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic qwait;
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; qwait; scl_m = 1'b1; qwait; m_sda = 1'b0; qwait; scl_m = 1'b0; qwait;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; qwait; scl_m = 1'b1; qwait; m_sda = 1'b1; qwait;
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b; qwait; scl_m = 1'b1; qwait; qwait; scl_m = 1'b0; qwait;
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1; qwait; scl_m = 1'b1; qwait; b = sda; qwait; scl_m = 1'b0; qwait;
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(v[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      v[i] = b;
    end
    wr_bit(ack);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [8:0] t;
    logic       nack;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic       ack;
    logic       bt;
    logic [7:0] b0, b1, b2, b3;
    logic [3:0] nib;
    int         am0, rd0;
    logic       wr_nack;
`ifdef LM75A_POINTER_WRITE_EN
    wr_nack = 1'b0;
`else
    wr_nack = 1'b1;
`endif
    vecs[0] = '{8'h91, 9'h033, 1'b0, 8'h19, 8'h80};
    vecs[1] = '{8'h91, 9'h1CE, 1'b0, 8'hE7, 8'h00};
    vecs[2] = '{8'h93, 9'h033, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{8'h01, 9'h033, 1'b1, 8'h00, 8'h00};
    vecs[4] = '{8'h00, 9'h033, 1'b1, 8'h00, 8'h00};
    vecs[5] = '{8'h91, 9'h0FF, 1'b0, 8'h7F, 8'h80};
    vecs[6] = '{8'h91, 9'h100, 1'b0, 8'h80, 8'h00};
    vecs[7] = '{8'h90, 9'h033, wr_nack, 8'h00, 8'h00};
    vecs[8] = '{8'h92, 9'h033, 1'b1, 8'h00, 8'h00};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_sda", {15'd0, sda}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_am", {15'd0, addr_match}, 16'd0);
    check("rst_rdd", {15'd0, rd_done}, 16'd0);
    rst = 1'b0;
    qwait;

    // Table-driven transactions
    for (int v = 0; v < 9; v++) begin
      temp = vecs[v].t;
      am0 = am_cnt; rd0 = rd_cnt;
      drv_seen = 1'b0;
      i2c_start;
      wr_byte(vecs[v].addr, ack);
      check($sformatf("v%0d_addr_ack", v), {15'd0, ack}, {15'd0, vecs[v].nack});
      if (!vecs[v].nack) begin
        check($sformatf("v%0d_am", v), 16'(am_cnt - am0), 16'd1);
        check($sformatf("v%0d_busy", v), {15'd0, busy}, 16'd1);
        if (vecs[v].addr[0]) begin
          rd_byte(b0, 1'b0);
          rd_byte(b1, 1'b1);
          check($sformatf("v%0d_b0", v), {8'd0, b0}, {8'd0, vecs[v].b0});
          check($sformatf("v%0d_b1", v), {8'd0, b1}, {8'd0, vecs[v].b1});
          check($sformatf("v%0d_rddone", v), 16'(rd_cnt - rd0), 16'd1);
        end
      end else begin
        check($sformatf("v%0d_no_am", v), 16'(am_cnt - am0), 16'd0);
        check($sformatf("v%0d_no_drive", v), {15'd0, drv_seen}, 16'd0);
      end
      i2c_stop;
      check($sformatf("v%0d_busy_end", v), {15'd0, busy}, 16'd0);
    end

    // Snapshot: temp changes right after the ACK, bytes still from 0x033;
    // bytes 2 and 3 repeat 0 and 1.
    temp = 9'h033;
    rd0 = rd_cnt;
    i2c_start;
    wr_byte(8'h91, ack);
    temp = 9'h0FE;
    check("snap_ack", {15'd0, ack}, 16'd0);
    rd_byte(b0, 1'b0);
    rd_byte(b1, 1'b0);
    rd_byte(b2, 1'b0);
    rd_byte(b3, 1'b1);
    check("snap_b0", {8'd0, b0}, 16'h19);
    check("snap_b1", {8'd0, b1}, 16'h80);
    check("snap_b2", {8'd0, b2}, 16'h19);
    check("snap_b3", {8'd0, b3}, 16'h80);
    check("snap_rddone", 16'(rd_cnt - rd0), 16'd1);
    i2c_stop;

    // STOP after 4 bits of byte0, then a clean read.
    temp = 9'h033;
    rd0 = rd_cnt;
    i2c_start;
    wr_byte(8'h91, ack);
    check("abort_ack", {15'd0, ack}, 16'd0);
    for (int i = 3; i >= 0; i--) begin
      rd_bit(bt);
      nib[i] = bt;
    end
    check("abort_nib", {12'd0, nib}, 16'h1);
    m_sda = 1'b0; qwait; scl_m = 1'b1; qwait; m_sda = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_sda", {15'd0, sda}, 16'd1);
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_no_rddone", 16'(rd_cnt - rd0), 16'd0);
    qwait;
    i2c_start;
    wr_byte(8'h91, ack);
    rd_byte(b0, 1'b0);
    rd_byte(b1, 1'b1);
    i2c_stop;
    check("post_abort_ack", {15'd0, ack}, 16'd0);
    check("post_abort_b0", {8'd0, b0}, 16'h19);
    check("post_abort_b1", {8'd0, b1}, 16'h80);

`ifdef LM75A_POINTER_WRITE_EN
    // Pointer = Tos, repeated START, read.
    i2c_start;
    wr_byte(8'h90, ack); check("ptr_wa_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'h03, ack); check("ptr_wp_ack", {15'd0, ack}, 16'd0);
    i2c_start;
    wr_byte(8'h91, ack); check("ptr_ra_ack", {15'd0, ack}, 16'd0);
    rd_byte(b0, 1'b0);
    rd_byte(b1, 1'b1);
    i2c_stop;
    check("tos_b0", {8'd0, b0}, 16'h50);
    check("tos_b1", {8'd0, b1}, 16'h00);
    // Third write byte NACKed; pointer = config.
    i2c_start;
    wr_byte(8'h90, ack);
    wr_byte(8'hF1, ack); check("conf_wp_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'hAA, ack); check("third_nack", {15'd0, ack}, 16'd1);
    i2c_stop;
    i2c_start;
    wr_byte(8'h91, ack);
    rd_byte(b0, 1'b0);
    rd_byte(b1, 1'b1);
    i2c_stop;
    check("conf_b0", {8'd0, b0}, 16'h00);
    check("conf_b1", {8'd0, b1}, 16'h00);
    // Thyst persists across transactions.
    i2c_start;
    wr_byte(8'h90, ack);
    wr_byte(8'h02, ack);
    i2c_stop;
    i2c_start;
    wr_byte(8'h91, ack);
    rd_byte(b0, 1'b0);
    rd_byte(b1, 1'b1);
    i2c_stop;
    check("thyst_b0", {8'd0, b0}, 16'h4B);
    check("thyst_b1", {8'd0, b1}, 16'h00);
`endif

    // Reset while the ACK is being driven releases sda at once.
    i2c_start;
    for (int i = 7; i >= 0; i--) wr_bit(bt_of(8'h91, i));
    m_sda = 1'b1;
    qwait;
    check("mid_ack_low", {15'd0, sda}, 16'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_sda", {15'd0, sda}, 16'd1);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    qwait;
    i2c_stop;
    temp = 9'h1CE;
    i2c_start;
    wr_byte(8'h91, ack);
    rd_byte(b0, 1'b0);
    rd_byte(b1, 1'b1);
    i2c_stop;
    check("post_rst_ack", {15'd0, ack}, 16'd0);
    check("post_rst_b0", {8'd0, b0}, 16'hE7);
    check("post_rst_b1", {8'd0, b1}, 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic bt_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
